// File: rtl/traffic_ctrl.sv
// Traffic light controller: timed vehicle phases, a pedestrian walk phase
// inserted after amber on request, and a flashing-amber fault mode.
// All outputs are registered and decoded from the next state only.
module traffic_ctrl #(
  parameter int CNT_W      = 8,
  parameter int T_RED      = 4,
  parameter int T_RA       = 2,
  parameter int T_GREEN    = 6,
  parameter int T_AMBER    = 2,
  parameter int T_WALK     = 4,
  parameter int FLASH_HALF = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       flash,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic       red,
  output logic       amber,
  output logic       green,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_RED       = 3'd0,
    ST_RED_AMBER = 3'd1,
    ST_GREEN     = 3'd2,
    ST_AMBER     = 3'd3,
    ST_WALK      = 3'd4,
    ST_FLASH_ON  = 3'd5,
    ST_FLASH_OFF = 3'd6,
    ST_ILLEGAL   = 3'd7
  } state_t;

  // Timer reload values: a phase of T cycles counts T-1 down to 0.
  localparam logic [CNT_W-1:0] LD_RED     = CNT_W'(T_RED - 1);
  localparam logic [CNT_W-1:0] LD_RA      = CNT_W'(T_RA - 1);
  localparam logic [CNT_W-1:0] LD_GREEN   = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_AMBER   = CNT_W'(T_AMBER - 1);
  localparam logic [CNT_W-1:0] LD_WALK    = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] LD_FLASH   = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] TIMER_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] TIMER_ONE  = CNT_W'(1);

  // Lamp pattern {red, amber, green, walk} for a state; anything
  // unrecognised shows red, the safe aspect.
  function automatic logic [3:0] lamp_decode(input state_t st);
    logic [3:0] lamps;
    case (st)
      ST_RED:       lamps = 4'b1000;
      ST_RED_AMBER: lamps = 4'b1100;
      ST_GREEN:     lamps = 4'b0010;
      ST_AMBER:     lamps = 4'b0100;
      ST_WALK:      lamps = 4'b1001;
      ST_FLASH_ON:  lamps = 4'b0100;
      ST_FLASH_OFF: lamps = 4'b0000;
      default:      lamps = 4'b1000;
    endcase
    return lamps;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  state_t           adv_state_s;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] timer_nxt_s;
  logic [CNT_W-1:0] adv_load_s;
  logic             pend_r;
  logic             pend_nxt_s;
  logic             accept_s;
  logic             in_flash_s;
  logic             ped_ack_r;
  logic [3:0]       lamps_r;
  logic [2:0]       phase_r;

  // Successor state and its dwell reload, used when the current dwell expires.
  always_comb begin
    adv_state_s = ST_RED;
    adv_load_s  = LD_RED;
    case (state_r)
      ST_RED:       begin adv_state_s = ST_RED_AMBER; adv_load_s = LD_RA;    end
      ST_RED_AMBER: begin adv_state_s = ST_GREEN;     adv_load_s = LD_GREEN; end
      ST_GREEN:     begin adv_state_s = ST_AMBER;     adv_load_s = LD_AMBER; end
      ST_AMBER: begin
        if (pend_r) begin
          adv_state_s = ST_WALK;
          adv_load_s  = LD_WALK;
        end else begin
          adv_state_s = ST_RED;
          adv_load_s  = LD_RED;
        end
      end
      ST_WALK:      begin adv_state_s = ST_RED;       adv_load_s = LD_RED;   end
      ST_FLASH_ON:  begin adv_state_s = ST_FLASH_OFF; adv_load_s = LD_FLASH; end
      ST_FLASH_OFF: begin adv_state_s = ST_FLASH_ON;  adv_load_s = LD_FLASH; end
      default:      begin adv_state_s = ST_RED;       adv_load_s = LD_RED;   end
    endcase
  end

  // Next state and timer: illegal-code recovery, then flash entry/exit,
  // then the enabled dwell countdown; en=0 freezes everything else.
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    in_flash_s  = (state_r == ST_FLASH_ON) || (state_r == ST_FLASH_OFF);
    if (state_r == ST_ILLEGAL) begin
      state_nxt_s = ST_RED;
      timer_nxt_s = LD_RED;
    end else if (flash && !in_flash_s) begin
      state_nxt_s = ST_FLASH_ON;
      timer_nxt_s = LD_FLASH;
    end else if (!flash && in_flash_s) begin
      state_nxt_s = ST_RED;
      timer_nxt_s = LD_RED;
    end else if (en) begin
      if (timer_r == TIMER_ZERO) begin
        state_nxt_s = adv_state_s;
        timer_nxt_s = adv_load_s;
      end else begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r - TIMER_ONE;
      end
    end else begin
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;
    end
  end

  // Pedestrian request bookkeeping: accept only when nothing is pending and
  // the walk phase is neither active nor about to start; walk entry clears it.
  always_comb begin
    accept_s   = ped_req && !pend_r && (state_r != ST_WALK) && (state_nxt_s != ST_WALK);
    pend_nxt_s = pend_r;
    if ((state_nxt_s == ST_WALK) && (state_r != ST_WALK)) begin
      pend_nxt_s = 1'b0;
    end else if (accept_s) begin
      pend_nxt_s = 1'b1;
    end else begin
      pend_nxt_s = pend_r;
    end
  end

  // State, timer, pending flag and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RED;
      timer_r   <= LD_RED;
      pend_r    <= 1'b0;
      ped_ack_r <= 1'b0;
      lamps_r   <= 4'b1000;
      phase_r   <= 3'd0;
    end else begin
      state_r   <= state_nxt_s;
      timer_r   <= timer_nxt_s;
      pend_r    <= pend_nxt_s;
      ped_ack_r <= accept_s;
      lamps_r   <= lamp_decode(state_nxt_s);
      phase_r   <= state_nxt_s;
    end
  end

  assign red     = lamps_r[3];
  assign amber   = lamps_r[2];
  assign green   = lamps_r[1];
  assign walk    = lamps_r[0];
  assign phase   = phase_r;
  assign ped_ack = ped_ack_r;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Scoreboard bench for traffic_ctrl: each scenario queues the expected
// per-cycle phase/lamps/ack, then pops and compares at every falling edge.
module tb_traffic_ctrl;

  typedef struct packed {
    logic [2:0] ph;
    logic [3:0] lamps;
    logic       ack;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       flash;
  logic       ped_req;
  logic       ped_ack;
  logic       red, amber, green, walk;
  logic [2:0] phase;

  logic       flash_one;
  logic       ped_one;
  logic       ack1;
  logic       red1, amber1, green1, walk1;
  logic [2:0] phase1;

  int   checks;
  int   errors;
  exp_t sb_q[$];

  traffic_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flash(flash), .ped_req(ped_req),
    .ped_ack(ped_ack), .red(red), .amber(amber), .green(green), .walk(walk),
    .phase(phase)
  );

  traffic_ctrl #(
    .CNT_W(4), .T_RED(1), .T_RA(1), .T_GREEN(1), .T_AMBER(1), .T_WALK(1),
    .FLASH_HALF(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .flash(flash_one), .ped_req(ped_one),
    .ped_ack(ack1), .red(red1), .amber(amber1), .green(green1), .walk(walk1),
    .phase(phase1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lamp table {red, amber, green, walk} per phase code.
  function automatic logic [3:0] lamps_of(input logic [2:0] ph);
    case (ph)
      3'd0: return 4'b1000;
      3'd1: return 4'b1100;
      3'd2: return 4'b0010;
      3'd3: return 4'b0100;
      3'd4: return 4'b1001;
      3'd5: return 4'b0100;
      3'd6: return 4'b0000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic push_one(input logic [2:0] ph, input logic ack);
    exp_t e;
    e.ph = ph; e.lamps = lamps_of(ph); e.ack = ack;
    sb_q.push_back(e);
  endtask

  task automatic push_run(input logic [2:0] ph, input int n);
    for (int k = 0; k < n; k++) push_one(ph, 1'b0);
  endtask

  // Pulse reset and release it at a falling edge; outputs then show RED.
  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; flash = 1'b0; ped_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; flash = 1'b0; ped_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({phase, red, amber, green, walk, ped_ack} !== {3'd0, 4'b1000, 1'b0}) begin
      errors++;
      $display("FAIL reset outputs got %b exp %b", {phase, red, amber, green, walk, ped_ack}, {3'd0, 4'b1000, 1'b0});
    end
    ped_req = 1'b0;
  endtask

  task automatic test_free_run();
    exp_t e;
    int i;
    do_reset();
    sb_q.delete();
    for (int p = 0; p < 2; p++) begin
      push_run(3'd0, 4); push_run(3'd1, 2); push_run(3'd2, 6); push_run(3'd3, 2);
    end
    push_run(3'd0, 1);
    i = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (phase !== e.ph) begin errors++; $display("FAIL free_run phase[%0d] got %0d exp %0d", i, phase, e.ph); end
      checks++;
      if ({red, amber, green, walk} !== e.lamps) begin errors++; $display("FAIL free_run lamps[%0d] got %b exp %b", i, {red, amber, green, walk}, e.lamps); end
      @(negedge clk); i++;
    end
  endtask

  task automatic test_ped_cross();
    exp_t e;
    int i;
    do_reset();
    sb_q.delete();
    push_run(3'd0, 4); push_run(3'd1, 2); push_run(3'd2, 2); push_one(3'd2, 1'b1);
    push_run(3'd2, 3); push_run(3'd3, 2); push_run(3'd4, 4); push_run(3'd0, 4);
    push_run(3'd1, 1);
    i = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (phase !== e.ph) begin errors++; $display("FAIL ped_cross phase[%0d] got %0d exp %0d", i, phase, e.ph); end
      checks++;
      if ({red, amber, green, walk} !== e.lamps) begin errors++; $display("FAIL ped_cross lamps[%0d] got %b exp %b", i, {red, amber, green, walk}, e.lamps); end
      checks++;
      if (ped_ack !== e.ack) begin errors++; $display("FAIL ped_cross ack[%0d] got %b exp %b", i, ped_ack, e.ack); end
      ped_req = (i == 7);
      @(negedge clk); i++;
    end
  endtask

  task automatic test_repeat_req();
    exp_t e;
    int i;
    do_reset();
    sb_q.delete();
    push_run(3'd0, 4); push_run(3'd1, 2); push_run(3'd2, 2); push_one(3'd2, 1'b1);
    push_run(3'd2, 3); push_run(3'd3, 2); push_run(3'd4, 4); push_run(3'd0, 4);
    push_run(3'd1, 2); push_run(3'd2, 6); push_run(3'd3, 2); push_run(3'd0, 2);
    i = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (phase !== e.ph) begin errors++; $display("FAIL repeat_req phase[%0d] got %0d exp %0d", i, phase, e.ph); end
      checks++;
      if (ped_ack !== e.ack) begin errors++; $display("FAIL repeat_req ack[%0d] got %b exp %b", i, ped_ack, e.ack); end
      ped_req = (i == 7) || (i == 9) || (i == 15);
      @(negedge clk); i++;
    end
  endtask

  task automatic test_en_hold();
    exp_t e;
    int i;
    do_reset();
    sb_q.delete();
    push_run(3'd0, 4); push_run(3'd1, 2); push_run(3'd2, 5); push_one(3'd2, 1'b1);
    push_run(3'd2, 5); push_run(3'd3, 2); push_run(3'd4, 4); push_run(3'd0, 2);
    i = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (phase !== e.ph) begin errors++; $display("FAIL en_hold phase[%0d] got %0d exp %0d", i, phase, e.ph); end
      checks++;
      if ({red, amber, green, walk} !== e.lamps) begin errors++; $display("FAIL en_hold lamps[%0d] got %b exp %b", i, {red, amber, green, walk}, e.lamps); end
      checks++;
      if (ped_ack !== e.ack) begin errors++; $display("FAIL en_hold ack[%0d] got %b exp %b", i, ped_ack, e.ack); end
      en      = !((i >= 8) && (i <= 12));
      ped_req = (i == 10);
      @(negedge clk); i++;
    end
    en = 1'b1;
  endtask

  task automatic test_flash();
    exp_t e;
    int i;
    do_reset();
    sb_q.delete();
    push_run(3'd0, 4); push_run(3'd1, 1);
    push_run(3'd5, 2); push_run(3'd6, 2); push_run(3'd5, 2); push_run(3'd6, 2);
    push_run(3'd0, 4); push_run(3'd1, 2); push_run(3'd2, 1);
    i = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (phase !== e.ph) begin errors++; $display("FAIL flash phase[%0d] got %0d exp %0d", i, phase, e.ph); end
      checks++;
      if ({red, amber, green, walk} !== e.lamps) begin errors++; $display("FAIL flash lamps[%0d] got %b exp %b", i, {red, amber, green, walk}, e.lamps); end
      flash = (i >= 4) && (i <= 11);
      @(negedge clk); i++;
    end
    flash = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    int i;
    do_reset();
    sb_q.delete();
    push_run(3'd0, 4); push_run(3'd1, 2); push_run(3'd2, 6); push_run(3'd3, 1);
    i = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (phase !== e.ph) begin errors++; $display("FAIL async_reset pre phase[%0d] got %0d exp %0d", i, phase, e.ph); end
      ped_req = (i == 7);
      if (i == 12) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({phase, red, amber, green, walk} !== {3'd0, 4'b1000}) begin
          errors++;
          $display("FAIL async_reset immediate got %b exp %b", {phase, red, amber, green, walk}, {3'd0, 4'b1000});
        end
      end
      @(negedge clk); i++;
    end
    rst_n = 1'b1;
    push_run(3'd0, 4); push_run(3'd1, 2); push_run(3'd2, 6); push_run(3'd3, 2);
    push_run(3'd0, 2);
    i = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (phase !== e.ph) begin errors++; $display("FAIL async_reset post phase[%0d] got %0d exp %0d", i, phase, e.ph); end
      @(negedge clk); i++;
    end
  endtask

  task automatic test_min_dwell();
    exp_t e;
    int i;
    do_reset();
    sb_q.delete();
    for (int p = 0; p < 2; p++) begin
      push_run(3'd0, 1); push_run(3'd1, 1); push_run(3'd2, 1); push_run(3'd3, 1);
    end
    i = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (phase1 !== e.ph) begin errors++; $display("FAIL min_dwell phase[%0d] got %0d exp %0d", i, phase1, e.ph); end
      checks++;
      if ({red1, amber1, green1, walk1, ack1} !== {e.lamps, 1'b0}) begin
        errors++;
        $display("FAIL min_dwell lamps[%0d] got %b exp %b", i, {red1, amber1, green1, walk1, ack1}, {e.lamps, 1'b0});
      end
      @(negedge clk); i++;
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; en = 1'b1; flash = 1'b0; ped_req = 1'b0;
    flash_one = 1'b0; ped_one = 1'b0;
    test_reset();
    test_free_run();
    test_ped_cross();
    test_repeat_req();
    test_en_hold();
    test_flash();
    test_async_reset();
    test_min_dwell();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/traffic_ctrl.md
TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, dwell-timer width in bits.
REQ-002 SHALL have parameters T_RED=4, T_RA=2, T_GREEN=6, T_AMBER=2, T_WALK=4: dwell cycles per phase; each is at least 1 and at most 2^CNT_W.
REQ-003 SHALL have parameter FLASH_HALF, default 2: cycles per half-period of amber flash.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: run enable; 0 freezes timer and state.
REQ-007 SHALL have port flash, input, 1 bit: fault mode request, flashing amber.
REQ-008 SHALL have port ped_req, input, 1 bit: pedestrian crossing request, level-sampled.
REQ-009 SHALL have port ped_ack, output, 1 bit: one-cycle pulse when a request is accepted.
REQ-010 SHALL have ports red, amber and green, outputs, 1 bit each: lamp drives.
REQ-011 SHALL have port walk, output, 1 bit: pedestrian walk lamp.
REQ-012 SHALL have port phase, output, 3 bits: current state code.

Function
REQ-013 SHALL implement states and codes RED=0, RED_AMBER=1, GREEN=2, AMBER=3, WALK=4, FLASH_ON=5, FLASH_OFF=6; codes 7 and above are illegal and SHALL recover to RED next cycle.
REQ-014 SHALL register all outputs and decode them from state only (Moore):
- RED: red=1.
- RED_AMBER: red=1, amber=1.
- GREEN: green=1.
- AMBER: amber=1.
- WALK: red=1, walk=1.
- FLASH_ON: amber=1.
- FLASH_OFF: all lamps 0.
REQ-015 SHALL load the timer with T_x-1 on entry to a timed state; each enabled cycle, timer==0 SHALL transition, otherwise the timer decrements.
REQ-016 SHALL hold each timed state for exactly T_x enabled cycles; with all T_x=1 the block SHALL step red -> red+amber -> green -> amber -> red once per cycle.
REQ-017 SHALL follow the normal sequence RED -> RED_AMBER -> GREEN -> AMBER -> RED.
REQ-018 SHALL go from AMBER to WALK, not RED, on expiry when the pending flag is 1.
REQ-019 SHALL clear the pending flag on WALK entry, and go from WALK to RED on expiry.
REQ-020 SHALL set the pending flag and pulse ped_ack on the next cycle when ped_req=1, pending=0, and state is neither WALK nor a cycle entering WALK.
REQ-021 SHALL otherwise ignore ped_req (no ack, no change to pending).
REQ-022 SHALL accept ped_req regardless of en.
REQ-023 SHALL, when en=0, freeze timer and state, keep outputs stable, and produce no transitions.
REQ-024 SHALL give flash priority over en and timers:
- flash=1 in any non-flash state enters FLASH_ON next cycle with timer FLASH_HALF-1.
- Alternates FLASH_ON and FLASH_OFF every FLASH_HALF cycles.
REQ-025 SHALL, when flash=0 in FLASH_ON or FLASH_OFF, enter RED next cycle with a full T_RED dwell; pending SHALL be retained.
REQ-026 SHALL, in flash states, advance the flash timer only when en=1.

Reset
REQ-027 SHALL, on rst_n=0, immediately force state RED, timer T_RED-1, pending 0, ped_ack 0, red=1, amber=0, green=0, walk=0, phase=0.
REQ-028 SHALL resume on the first rising clk edge after rst_n deasserts, with RED dwelling a full T_RED cycles; reset mid-phase SHALL discard any pending request.

Verification
REQ-029 SHALL verify free run with defaults, en=1: from reset, phase is 0 x4, 1 x2, 2 x6, 3 x2, then 0; period 14 cycles; outputs legal throughout.
REQ-030 SHALL verify pedestrian crossing: ped_req high 1 cycle during GREEN gives ped_ack one pulse next cycle; after AMBER, phase=4 for 4 cycles with red=1 and walk=1, then phase=0.
REQ-031 SHALL verify a repeated request: a second ped_req while pending=1 gives no ped_ack and still only one WALK phase.
REQ-032 SHALL verify enable hold: en=0 for 5 cycles mid-GREEN freezes phase=2; the remaining GREEN dwell completes after en=1.
REQ-033 SHALL verify flash: flash=1 during RED_AMBER gives amber 1,1,0,0,1,1...; on flash=0, phase=0 for 4 cycles.
REQ-034 SHALL verify asynchronous reset: rst_n low mid-AMBER, between clock edges, sets red=1, amber=0, phase=0 before the next edge.
